// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrating multiplexer feeding one registered output.
// The grant is chosen by fixed priority or round-robin, or it can be forced
// to a single channel. The output register accepts a new word whenever it is
// empty or is being drained in the same cycle, which sustains 1 word/cycle.
//
// Handshake: a word moves across a port on a rising edge only when that
// port's valid and ready are both high in the cycle before the edge. Upstream
// ready (in_ready) is combinational from the control inputs and never depends
// on in_data; downstream valid (out_valid) is a register output.
module arb_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
    parameter int RR    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [SEL_W-1:0]   force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel,
    output logic               o_dbg_full,
    output logic [SEL_W-1:0]   o_dbg_ptr
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_load_en;
    logic [N-1:0]       w_cand;
    logic               w_found;
    logic [SEL_W-1:0]   w_grant_idx;
    int                 w_best;
    int                 w_dist;
    logic [N-1:0]       w_grant;
    logic [WIDTH-1:0]   w_mux_data;
    logic               w_xfer;

    // Candidate set: all offering channels, or only the forced one.
    // A forced index of N or above matches no channel and grants nothing.
    always_comb begin
        w_cand = in_valid;
        if (force_en) begin
            for (int i = 0; i < N; i++) begin
                w_cand[i] = in_valid[i] && (force_sel == SEL_W'(i));
            end
        end
    end

    // Pick the candidate with the smallest search distance. Fixed priority
    // uses the index itself; round-robin measures distance from ptr+1 mod N.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_best      = N;
        w_dist      = 0;
        for (int i = 0; i < N; i++) begin
            if (RR != 0) begin
                w_dist = (i + N - 1 - int'(r_ptr)) % N;
            end else begin
                w_dist = i;
            end
            if (w_cand[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_grant_idx = SEL_W'(i);
            end
        end
    end

    // One-hot grant and the AND-OR data select it drives.
    always_comb begin
        w_grant    = '0;
        w_mux_data = '0;
        for (int i = 0; i < N; i++) begin
            w_grant[i] = w_found && (w_grant_idx == SEL_W'(i));
            if (w_grant[i]) begin
                w_mux_data = w_mux_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load_en = (r_state == ST_EMPTY) || out_ready;
    // Reset suppresses every ready so nothing is accepted in the reset cycle.
    assign in_ready  = (w_load_en && !reset) ? w_grant : '0;
    assign w_xfer    = |in_ready;

    // Next state: a transfer always fills; a drain without a refill empties.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State register for the EMPTY/FULL output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output word, its source index and the round-robin pointer; all written
    // only on a transfer so an idle input never reaches out_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= SEL_W'(N - 1);
        end else if (w_xfer) begin
            r_data <= w_mux_data;
            r_sel  <= w_grant_idx;
            if (RR != 0) begin
                r_ptr <= w_grant_idx;
            end
        end
    end

    assign out_data   = r_data;
    assign out_sel    = r_sel;
    assign out_valid  = (r_state == ST_FULL);
    assign o_dbg_full = (r_state == ST_FULL);
    assign o_dbg_ptr  = r_ptr;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed vector table against a round-robin instance, plus
// short sequences for fixed priority, round-robin fairness and a one-channel
// instance that exercises an out-of-range forced select.
module tb_arb_mux_n;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           force_en;
    logic [1:0]     force_sel;
    logic           out_ready;

    logic [N-1:0]   rr_in_ready, fp_in_ready;
    logic [W-1:0]   rr_out_data, fp_out_data;
    logic           rr_out_valid, fp_out_valid;
    logic [1:0]     rr_out_sel, fp_out_sel;
    logic           rr_full, fp_full;
    logic [1:0]     rr_ptr, fp_ptr;

    logic [W-1:0]   one_in_data;
    logic [0:0]     one_in_valid;
    logic [0:0]     one_in_ready;
    logic           one_force_en;
    logic [0:0]     one_force_sel;
    logic [W-1:0]   one_out_data;
    logic           one_out_valid;
    logic           one_out_ready;
    logic [0:0]     one_out_sel;
    logic           one_full;
    logic [0:0]     one_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock and the three instances sharing it.
    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_sel(rr_out_sel), .o_dbg_full(rr_full), .o_dbg_ptr(rr_ptr)
    );

    arb_mux_n #(.WIDTH(W), .N(N), .RR(0)) dut_fp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(out_ready),
        .out_sel(fp_out_sel), .o_dbg_full(fp_full), .o_dbg_ptr(fp_ptr)
    );

    arb_mux_n #(.WIDTH(W), .N(1), .RR(1)) dut_one (
        .clk(clk), .reset(reset), .in_data(one_in_data), .in_valid(one_in_valid),
        .in_ready(one_in_ready), .force_en(one_force_en), .force_sel(one_force_sel),
        .out_data(one_out_data), .out_valid(one_out_valid), .out_ready(one_out_ready),
        .out_sel(one_out_sel), .o_dbg_full(one_full), .o_dbg_ptr(one_ptr)
    );

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       fen;
        logic [1:0] fsel;
        logic       ordy;
        logic [31:0] base;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_sel;
        logic [31:0] e_data;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // Channel i carries base + i so the source of a word is visible in it.
    task automatic drive(input logic rst, input logic [3:0] vld, input logic fen,
                         input logic [1:0] fsel, input logic ordy, input logic [31:0] base);
        reset     = rst;
        in_valid  = vld;
        force_en  = fen;
        force_sel = fsel;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = base + 32'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int g);
        logic [3:0] v;
        v = 4'b0001;
        return v << g;
    endfunction

    initial begin
        int g_exp;
        int cnt[4];
        logic [3:0] grabbed;

        drive(1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 32'h0);
        one_in_valid  = 1'b0;
        one_in_data   = '0;
        one_force_en  = 1'b0;
        one_force_sel = 1'b0;
        one_out_ready = 1'b1;

        // Vector table: rst vld fen fsel ordy base | rdy ov sel data ptr
        vt.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 32'h0,        4'b0000, 1'b0, 2'd0, 32'h0,        2'd3});
        vt.push_back('{1'b1, 4'b0100, 1'b0, 2'd0, 1'b1, 32'hDEADBEED, 4'b0000, 1'b0, 2'd0, 32'h0,        2'd3});
        vt.push_back('{1'b0, 4'b0100, 1'b0, 2'd0, 1'b1, 32'hDEADBEED, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF, 2'd2});
        vt.push_back('{1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 32'h0,        4'b0000, 1'b0, 2'd0, 32'h0,        2'd3});
        for (int k = 0; k < 8; k++) begin
            vt.push_back('{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 32'h1000_0000 + 32'(k*16),
                           oh(k % 4), 1'b1, 2'(k % 4), 32'h1000_0000 + 32'(k*16) + 32'(k % 4), 2'(k % 4)});
        end
        vt.push_back('{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 32'h12345678, 4'b0001, 1'b1, 2'd0, 32'h12345678, 2'd0});
        for (int k = 0; k < 5; k++) begin
            vt.push_back('{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 32'h0,    4'b0000, 1'b1, 2'd0, 32'h12345678, 2'd0});
        end
        vt.push_back('{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 32'h2000_0000, 4'b0010, 1'b1, 2'd1, 32'h2000_0001, 2'd1});
        vt.push_back('{1'b0, 4'b0111, 1'b1, 2'd3, 1'b1, 32'h0,         4'b0000, 1'b0, 2'd1, 32'h2000_0001, 2'd1});
        vt.push_back('{1'b0, 4'b1111, 1'b1, 2'd3, 1'b1, 32'h3000_0000, 4'b1000, 1'b1, 2'd3, 32'h3000_0003, 2'd3});
        vt.push_back('{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 32'h4000_0000, 4'b0001, 1'b1, 2'd0, 32'h4000_0000, 2'd0});
        vt.push_back('{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 32'h0,         4'b0000, 1'b0, 2'd0, 32'h4000_0000, 2'd0});
        vt.push_back('{1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 32'h5000_0000, 4'b0100, 1'b1, 2'd2, 32'h5000_0002, 2'd2});
        vt.push_back('{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0,         4'b0000, 1'b1, 2'd2, 32'h5000_0002, 2'd2});
        vt.push_back('{1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 32'h0,         4'b0000, 1'b0, 2'd0, 32'h0,        2'd3});
        vt.push_back('{1'b0, 4'b1001, 1'b0, 2'd0, 1'b1, 32'h6000_0000, 4'b0001, 1'b1, 2'd0, 32'h6000_0000, 2'd0});
        vt.push_back('{1'b0, 4'b1001, 1'b0, 2'd0, 1'b1, 32'h7000_0000, 4'b1000, 1'b1, 2'd3, 32'h7000_0003, 2'd3});
        vt.push_back('{1'b0, 4'b1001, 1'b0, 2'd0, 1'b1, 32'h7100_0000, 4'b0001, 1'b1, 2'd0, 32'h7100_0000, 2'd0});

        for (int v = 0; v < vt.size(); v++) begin
            drive(vt[v].rst, vt[v].vld, vt[v].fen, vt[v].fsel, vt[v].ordy, vt[v].base);
            #1;
            chk("in_ready", v, 32'(rr_in_ready), 32'(vt[v].e_rdy));
            tick();
            chk("out_valid", v, 32'(rr_out_valid), 32'(vt[v].e_ov));
            chk("out_sel",   v, 32'(rr_out_sel),   32'(vt[v].e_sel));
            chk("out_data",  v, rr_out_data,       vt[v].e_data);
            chk("ptr",       v, 32'(rr_ptr),       32'(vt[v].e_ptr));
        end

        // Fixed priority: channel 1 always beats 3; round-robin alternates 1,3.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 32'h8000_0000 + 32'(c*16));
            #1;
            chk("fp_in_ready", c, 32'(fp_in_ready), 32'(4'b0010));
            chk("rr_alt_ready", c, 32'(rr_in_ready), 32'(((c % 2) == 0) ? 4'b0010 : 4'b1000));
            tick();
            chk("fp_out_sel",  c, 32'(fp_out_sel),  32'd1);
            chk("fp_out_data", c, fp_out_data, 32'h8000_0000 + 32'(c*16) + 32'd1);
        end

        // Fairness: rr ptr is now 3, so eight transfers run 0..3 twice.
        for (int g = 0; g < 4; g++) cnt[g] = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 32'h9000_0000);
            #1;
            grabbed = rr_in_ready;
            g_exp = c % 4;
            chk("fair_ready", c, 32'(grabbed), 32'(oh(g_exp)));
            for (int g = 0; g < 4; g++) if (grabbed[g]) cnt[g]++;
            tick();
        end
        for (int g = 0; g < 4; g++) chk("fair_count", g, 32'(cnt[g]), 32'd2);

        // One-channel instance: plain pipeline register; forced index 1 is out of range.
        drive(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 32'h0);
        one_in_valid = 1'b1; one_in_data = 32'hAAAA_0001; one_force_en = 1'b0; one_out_ready = 1'b1;
        #1;
        chk("one_ready", 0, 32'(one_in_ready), 32'd1);
        tick();
        chk("one_valid", 0, 32'(one_out_valid), 32'd1);
        chk("one_data",  0, one_out_data, 32'hAAAA_0001);
        chk("one_sel",   0, 32'(one_out_sel), 32'd0);
        one_force_en = 1'b1; one_force_sel = 1'b1; one_in_data = 32'hAAAA_0009;
        #1;
        chk("one_ready", 1, 32'(one_in_ready), 32'd0);
        tick();
        chk("one_valid", 1, 32'(one_out_valid), 32'd0);
        chk("one_data",  1, one_out_data, 32'hAAAA_0001);
        one_force_sel = 1'b0; one_in_data = 32'hAAAA_0002;
        #1;
        chk("one_ready", 2, 32'(one_in_ready), 32'd1);
        tick();
        chk("one_valid", 2, 32'(one_out_valid), 32'd1);
        chk("one_data",  2, one_out_data, 32'hAAAA_0002);
        chk("one_ptr",   2, 32'(one_ptr), 32'd0);
        one_out_ready = 1'b0; one_in_data = 32'hAAAA_0003;
        #1;
        chk("one_ready", 3, 32'(one_in_ready), 32'd0);
        tick();
        chk("one_data",  3, one_out_data, 32'hAAAA_0002);
        chk("one_valid", 3, 32'(one_out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
